// File: rtl/traceback_control_if.sv
// rtl/traceback_control_if.sv - start/backpointer-read/state-stream bundle for traceback_control
interface traceback_control_if #(
  parameter int POS_W   = 4,
  parameter int STATE_W = 3
);
  logic               start_Traceback_control;
  logic [STATE_W-1:0] final_state_in;
  logic               bp_rd_en_out;
  logic [POS_W-1:0]   bp_addr_pos_out;
  logic [STATE_W-1:0] bp_addr_state_out;
  logic [STATE_W-1:0] bp_data_in;
  logic [STATE_W-1:0] state_out;
  logic [POS_W-1:0]   state_pos_out;
  logic               state_valid_out;
  logic               state_ready_in;
  logic               busy_out;
  logic               done_out;
  logic               err_out;

  // traceback block side
  modport master (
    input  start_Traceback_control, final_state_in, bp_data_in, state_ready_in,
    output bp_rd_en_out, bp_addr_pos_out, bp_addr_state_out,
           state_out, state_pos_out, state_valid_out, busy_out, done_out, err_out
  );

  // RAM / consumer / sequencer side
  modport slave (
    output start_Traceback_control, final_state_in, bp_data_in, state_ready_in,
    input  bp_rd_en_out, bp_addr_pos_out, bp_addr_state_out,
           state_out, state_pos_out, state_valid_out, busy_out, done_out, err_out
  );
endinterface

// File: rtl/traceback_control.sv
// rtl/traceback_control.sv - survivor-memory traceback walker; optional TRACEBACK_RANGE_CHECK_EN state range check
module traceback_control #(
  parameter int NUM_POS    = 11,
  parameter int POS_W      = 4,
  parameter int NUM_STATES = 5,
  parameter int STATE_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset_Traceback_control,
  traceback_control_if.master  bus
);

  typedef enum logic [1:0] {IDLE, EMIT, WAIT, DONE} fsm_t;

  fsm_t               st;
  logic [POS_W-1:0]   pos;
  logic [STATE_W-1:0] cur_state;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               rd;

`ifdef TRACEBACK_RANGE_CHECK_EN
  logic               err_q;

  function automatic logic out_of_range(input logic [STATE_W-1:0] v);
    return int'(v) >= NUM_STATES;
  endfunction
`endif

  // A read is issued only on the transfer cycle of a non-final position, so the
  // predecessor arrives exactly in the following WAIT cycle.
  assign rd = (st == EMIT) && bus.state_ready_in && (pos != '0);

  assign bus.bp_rd_en_out      = rd;
  assign bus.bp_addr_pos_out   = rd ? pos : '0;
  assign bus.bp_addr_state_out = rd ? cur_state : '0;
  assign bus.state_out         = cur_state;
  assign bus.state_pos_out     = pos;
  assign bus.state_valid_out   = valid_q;
  assign bus.busy_out          = busy_q;
  assign bus.done_out          = done_q;
`ifdef TRACEBACK_RANGE_CHECK_EN
  assign bus.err_out           = err_q;
`else
  assign bus.err_out           = 1'b0;
`endif

  // Traceback sequencer: state plus all registered outputs
  always_ff @(posedge clk or negedge reset_Traceback_control) begin
    if (!reset_Traceback_control) begin
      st        <= IDLE;
      pos       <= '0;
      cur_state <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TRACEBACK_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_Traceback_control) begin
            pos    <= POS_W'(NUM_POS - 1);
            busy_q <= 1'b1;
`ifdef TRACEBACK_RANGE_CHECK_EN
            err_q  <= 1'b0;
            if (out_of_range(bus.final_state_in)) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              st     <= DONE;
            end else begin
              cur_state <= bus.final_state_in;
              valid_q   <= 1'b1;
              st        <= EMIT;
            end
`else
            cur_state <= bus.final_state_in;
            valid_q   <= 1'b1;
            st        <= EMIT;
`endif
          end
        end
        EMIT: begin
          if (bus.state_ready_in) begin
            valid_q <= 1'b0;
            if (pos == '0) begin
              done_q <= 1'b1;
              st     <= DONE;
            end else begin
              st <= WAIT;
            end
          end
        end
        WAIT: begin
`ifdef TRACEBACK_RANGE_CHECK_EN
          if (out_of_range(bus.bp_data_in)) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            st     <= DONE;
          end else begin
            cur_state <= bus.bp_data_in;
            pos       <= pos - 1'b1;
            valid_q   <= 1'b1;
            st        <= EMIT;
          end
`else
          cur_state <= bus.bp_data_in;
          pos       <= pos - 1'b1;
          valid_q   <= 1'b1;
          st        <= EMIT;
`endif
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
